// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: byte FIFO feeding a UART transmitter through a
// load/strobe/gap handshake. Bytes are popped only when the UART reports
// txready, then presented on txdata with a one-cycle txclk load strobe,
// followed by GAP_CYCLES idle cycles before the next byte may go out.
//
// Optional feature: define UART_TX_CRLF_EN to expand every accepted push of
// 8'h0A (LF) into the pair 8'h0D, 8'h0A. The pair needs two free entries,
// otherwise the whole push is dropped and overflow is raised.
module uart_tx_buffer #(
  parameter int DEPTH      = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     nRST,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     clear_ovf,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [7:0]               txdata,
  output logic                     txclk,
  input  logic                     txready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);
`ifdef UART_TX_CRLF_EN
  localparam logic [CW-1:0] LP_CRLF_MAX = CW'(DEPTH - 2);
`endif

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STROBE,
    GAP
  } state_t;

  state_t          r_state;
  logic [7:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wrPtr;
  logic [AW-1:0]   r_rdPtr;
  logic [CW-1:0]   r_count;
  logic [GW-1:0]   r_gapCnt;
  logic            r_overflow;
  logic [7:0]      r_txdata;
  logic            r_txclk;

  logic            w_full;
  logic            w_empty;
  logic            w_pop;
  logic            w_wrOne;
  logic            w_wrTwo;
  logic            w_drop;
  logic [1:0]      w_wrCnt;

  assign w_full   = (r_count == LP_DEPTH);
  assign w_empty  = (r_count == '0);
  assign w_pop    = (r_state == IDLE) && !w_empty && txready;
  assign w_wrCnt  = {w_wrTwo, w_wrOne};

  assign full     = w_full;
  assign empty    = w_empty;
  assign count    = r_count;
  assign overflow = r_overflow;
  assign txdata   = r_txdata;
  assign txclk    = r_txclk;

  // Decide whether this cycle's push is written (one or two entries) or dropped.
  always_comb begin
    w_wrOne = 1'b0;
    w_wrTwo = 1'b0;
    w_drop  = 1'b0;
    if (push) begin
`ifdef UART_TX_CRLF_EN
      if (push_data == 8'h0A) begin
        if (r_count <= LP_CRLF_MAX) w_wrTwo = 1'b1;
        else                        w_drop  = 1'b1;
      end else if (!w_full) begin
        w_wrOne = 1'b1;
      end else begin
        w_drop = 1'b1;
      end
`else
      if (!w_full) w_wrOne = 1'b1;
      else         w_drop  = 1'b1;
`endif
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_wrOne) r_mem[r_wrPtr] <= push_data;
`ifdef UART_TX_CRLF_EN
    if (w_wrTwo) begin
      r_mem[r_wrPtr]          <= 8'h0D;
      r_mem[r_wrPtr + AW'(1)] <= 8'h0A;
    end
`endif
  end

  // Pointers, occupancy count and the sticky overflow flag (set beats clear).
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_wrPtr <= r_wrPtr + AW'(w_wrCnt);
      r_rdPtr <= r_rdPtr + AW'(w_pop);
      r_count <= r_count + CW'(w_wrCnt) - CW'(w_pop);
      if (w_drop)         r_overflow <= 1'b1;
      else if (clear_ovf) r_overflow <= 1'b0;
    end
  end

  // Transmit handshake: pop into txdata, strobe txclk once, then hold off for the gap.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_state  <= IDLE;
      r_txdata <= 8'h00;
      r_txclk  <= 1'b0;
      r_gapCnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_txclk <= 1'b0;
          if (w_pop) begin
            r_txdata <= r_mem[r_rdPtr];
            r_state  <= LOAD;
          end
        end
        LOAD: begin
          r_txclk <= 1'b1;
          r_state <= STROBE;
        end
        STROBE: begin
          r_txclk  <= 1'b0;
          r_gapCnt <= GW'(GAP_CYCLES - 1);
          r_state  <= GAP;
        end
        GAP: begin
          r_txclk <= 1'b0;
          if (r_gapCnt == '0) r_state  <= IDLE;
          else                r_gapCnt <= r_gapCnt - GW'(1);
        end
        default: begin
          r_txclk <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
